// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: op encodings and default sizes.
package pc_pkg;
  localparam int PC_WIDTH_DEF    = 10;
  localparam int STACK_DEPTH_DEF = 4;

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_BREL = 3'b001;
  localparam logic [2:0] OP_JABS = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
endpackage

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO: count-indexed storage, no wrap, push ignored when full, pop ignored when empty.
module ret_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [CW-1:0]               count;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Top of stack lives at index count-1; a one-hot style compare keeps index widths exact.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++)
      if (count == CW'(i + 1)) dout = mem[i];
  end

  always_ff @(posedge clk) begin
    if (!reset)                 count <= '0;
    else if (push && !full)     count <= count + CW'(1);
    else if (pop && !empty)     count <= count - CW'(1);
  end

  // Entry contents are never cleared; count alone defines validity.
  always_ff @(posedge clk) begin
    if (reset && push && !full)
      for (int i = 0; i < DEPTH; i++)
        if (count == CW'(i)) mem[i] <= din;
  end
endmodule

// File: rtl/pc_unit.sv
// Program counter with relative/absolute branching, call/return via ret_stack, sticky stack error flags.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                PC_WIDTH     = PC_WIDTH_DEF,
  parameter int                STACK_DEPTH  = STACK_DEPTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_en,
  input  logic [2:0]          op,
  input  logic                cond,
  input  logic [PC_WIDTH-1:0] disp,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic                stack_empty,
  output logic                stack_full,
  output logic                stack_ovf,
  output logic                stack_unf
);
  logic [PC_WIDTH-1:0] pc_nxt, stk_top;
  logic                push, pop, ovf_set, unf_set;

  assign pc_plus1 = pc + PC_WIDTH'(1);

  // Same-width add: sign extension of disp and modulo wrap come for free.
  always_comb begin
    pc_nxt  = pc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (pc_en) begin
      case (op)
        OP_INC:  pc_nxt = pc_plus1;
        OP_BREL: pc_nxt = cond ? pc + disp : pc_plus1;
        OP_JABS: pc_nxt = cond ? target : pc_plus1;
        OP_CALL:
          if (stack_full) ovf_set = 1'b1;
          else begin
            push   = 1'b1;
            pc_nxt = target;
          end
        OP_RET:
          if (stack_empty) unf_set = 1'b1;
          else begin
            pop    = 1'b1;
            pc_nxt = stk_top;
          end
        default: pc_nxt = pc;
      endcase
    end
  end

  ret_stack #(.WIDTH(PC_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus1),
    .dout  (stk_top),
    .empty (stack_empty),
    .full  (stack_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= RESET_VECTOR;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      stack_ovf <= stack_ovf | ovf_set;
      stack_unf <= stack_unf | unf_set;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: queue-based reference model checked every cycle, plus literal spot checks.
module tb_pc_unit;
  localparam int          W     = 10;
  localparam int          DEPTH = 4;
  localparam int unsigned MASK  = (1 << W) - 1;
  localparam logic [W-1:0] RV   = 10'h010;

  logic         clk = 1'b0;
  logic         reset, pc_en, cond;
  logic [2:0]   op;
  logic [W-1:0] disp, target;
  logic [W-1:0] pc, pc_plus1;
  logic         stack_empty, stack_full, stack_ovf, stack_unf;

  int checks = 0;
  int errors = 0;

  int unsigned m_pc;
  int unsigned m_stk[$];
  bit          m_ovf, m_unf;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  pc_unit #(.PC_WIDTH(W), .STACK_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .op(op), .cond(cond),
    .disp(disp), .target(target), .pc(pc), .pc_plus1(pc_plus1),
    .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the stack is a queue, PC is an integer reduced mod 2^W.
  task automatic model_step(input bit r, input bit en, input logic [2:0] o, input bit c,
                            input int unsigned d, input int unsigned t);
    if (!r) begin
      m_pc = RV;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (en) begin
      case (o)
        3'd0: m_pc = (m_pc + 1) & MASK;
        3'd1: m_pc = c ? (m_pc + d) & MASK : (m_pc + 1) & MASK;
        3'd2: m_pc = c ? t : (m_pc + 1) & MASK;
        3'd3: if (m_stk.size() == DEPTH) m_ovf = 1;
              else begin m_stk.push_back((m_pc + 1) & MASK); m_pc = t; end
        3'd4: if (m_stk.size() == 0) m_unf = 1;
              else m_pc = m_stk.pop_back();
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit r, input bit en, input logic [2:0] o, input bit c,
                     input int unsigned d, input int unsigned t);
    reset = r; pc_en = en; op = o; cond = c; disp = W'(d); target = W'(t);
    @(posedge clk);
    model_step(r, en, o, c, d, t);
    chk_en = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",          32'(pc),          m_pc);
      chk("pc_plus1",    32'(pc_plus1),    (m_pc + 1) & MASK);
      chk("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
      chk("stack_full",  32'(stack_full),  32'(m_stk.size() == DEPTH));
      chk("stack_ovf",   32'(stack_ovf),   32'(m_ovf));
      chk("stack_unf",   32'(stack_unf),   32'(m_unf));
    end
  end

  initial begin
    reset = 1'b0; pc_en = 1'b0; op = '0; cond = 1'b0; disp = '0; target = '0;

    // Reset, increments, enable low
    cyc(0, 0, 3'd0, 0, 0, 0);
    cyc(0, 1, 3'd3, 0, 0, 10'h155);
    chk("lit_reset_pc", 32'(pc), 32'h010);
    chk("lit_reset_empty", 32'(stack_empty), 1);
    chk("lit_reset_flags", 32'({stack_ovf, stack_unf}), 0);
    repeat (3) cyc(1, 1, 3'd0, 0, 0, 0);
    chk("lit_inc3", 32'(pc), 32'h013);
    cyc(1, 0, 3'd0, 1, 0, 0);
    cyc(1, 0, 3'd3, 1, 0, 10'h200);
    chk("lit_hold_en0", 32'(pc), 32'h013);
    chk("lit_hold_en0_stack", 32'(stack_empty), 1);

    // Relative and absolute branches
    cyc(1, 1, 3'd2, 1, 0, 10'h100);
    cyc(1, 1, 3'd1, 1, 10'h3FC, 0);
    chk("lit_brel_neg", 32'(pc), 32'h0FC);
    cyc(1, 1, 3'd1, 0, 10'h008, 0);
    chk("lit_brel_nt", 32'(pc), 32'h0FD);
    cyc(1, 1, 3'd2, 1, 0, 10'h2AA);
    chk("lit_jabs", 32'(pc), 32'h2AA);
    cyc(1, 1, 3'd2, 0, 0, 10'h111);
    chk("lit_jabs_nt", 32'(pc), 32'h2AB);
    cyc(1, 1, 3'd0, 1, 10'h3FC, 10'h111);

    // Wraparound
    cyc(1, 1, 3'd2, 1, 0, 10'h3FF);
    cyc(1, 1, 3'd0, 0, 0, 0);
    chk("lit_inc_wrap", 32'(pc), 32'h000);
    cyc(1, 1, 3'd1, 1, 10'h3FF, 0);
    chk("lit_brel_wrap", 32'(pc), 32'h3FF);

    // Nested calls and returns
    cyc(1, 1, 3'd2, 1, 0, 10'h020);
    cyc(1, 1, 3'd3, 0, 0, 10'h100);
    cyc(1, 1, 3'd3, 1, 0, 10'h200);
    cyc(1, 1, 3'd3, 0, 0, 10'h300);
    chk("lit_call3", 32'(pc), 32'h300);
    cyc(1, 1, 3'd4, 0, 0, 0);
    chk("lit_ret1", 32'(pc), 32'h201);
    cyc(1, 1, 3'd4, 1, 0, 0);
    chk("lit_ret2", 32'(pc), 32'h101);
    cyc(1, 1, 3'd4, 0, 0, 0);
    chk("lit_ret3", 32'(pc), 32'h021);
    chk("lit_ret3_empty", 32'(stack_empty), 1);

    // Fill, overflow, reset, underflow
    cyc(1, 1, 3'd3, 0, 0, 10'h040);
    cyc(1, 1, 3'd3, 0, 0, 10'h050);
    cyc(1, 1, 3'd3, 0, 0, 10'h060);
    cyc(1, 1, 3'd3, 0, 0, 10'h070);
    chk("lit_full", 32'(stack_full), 1);
    cyc(1, 1, 3'd3, 1, 0, 10'h3F0);
    chk("lit_ovf_pc", 32'(pc), 32'h070);
    chk("lit_ovf", 32'(stack_ovf), 1);
    cyc(1, 1, 3'd0, 0, 0, 0);
    cyc(1, 1, 3'd4, 0, 0, 0);
    chk("lit_ret_after_ovf", 32'(pc), 32'h061);
    cyc(0, 1, 3'd0, 0, 0, 0);
    chk("lit_reset_clears_ovf", 32'(stack_ovf), 0);
    cyc(1, 1, 3'd4, 0, 0, 0);
    chk("lit_unf_pc", 32'(pc), 32'h010);
    chk("lit_unf", 32'(stack_unf), 1);
    cyc(1, 1, 3'd0, 0, 0, 0);
    cyc(1, 1, 3'd0, 0, 0, 0);
    chk("lit_unf_sticky", 32'(stack_unf), 1);

    // Call then immediate return
    cyc(1, 1, 3'd3, 0, 0, 10'h123);
    cyc(1, 1, 3'd4, 0, 0, 0);
    chk("lit_call_ret", 32'(pc), 32'h013);

    // Reset during a call, then HOLD opcodes
    cyc(1, 1, 3'd0, 0, 0, 0);
    cyc(0, 1, 3'd3, 1, 0, 10'h2F0);
    chk("lit_rst_call_pc", 32'(pc), 32'h010);
    chk("lit_rst_call_empty", 32'(stack_empty), 1);
    cyc(1, 1, 3'd5, 1, 10'h005, 10'h155);
    cyc(1, 1, 3'd6, 1, 10'h005, 10'h155);
    cyc(1, 1, 3'd7, 0, 10'h005, 10'h155);
    chk("lit_hold_ops", 32'(pc), 32'h010);
    cyc(1, 1, 3'd4, 0, 0, 0);

    chk_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; the next generation of the single-register PC.
- Holds the PC and computes next-PC for increment, conditional relative branch, conditional absolute jump, call and return.
- Call/return uses an internal return-address LIFO with sticky overflow/underflow flags.
- Sits between the control FSM (drives pc_en, op, cond) and instruction memory (consumes pc).

Parameters:
- PC_WIDTH, 10, width of PC, target and displacement.
- STACK_DEPTH, 4, number of return-address entries; must be ≥1.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- pc_en  input  1  commit enable; when 0 all state holds.
- op  input  3  000 INC, 001 BREL, 010 JABS, 011 CALL, 100 RET; 101-111 HOLD.
- cond  input  1  branch condition for BREL/JABS.
- disp  input  PC_WIDTH  signed two's-complement displacement for BREL.
- target  input  PC_WIDTH  absolute address for JABS/CALL.
- pc  output  PC_WIDTH  current PC (registered).
- pc_plus1  output  PC_WIDTH  pc+1 mod 2^PC_WIDTH (combinational from pc).
- stack_empty  output  1  no return addresses held (combinational from count).
- stack_full  output  1  STACK_DEPTH entries held.
- stack_ovf  output  1  sticky: CALL attempted while full.
- stack_unf  output  1  sticky: RET attempted while empty.

Behaviour:
- Reset (reset==0 at clock edge) has priority over everything, including a mid-sequence call or return:
  - pc=RESET_VECTOR, stack count=0, stack_ovf=0, stack_unf=0.
  - Consequently stack_empty=1 and stack_full=0.
  - Stack entry contents need not be cleared.
- pc_en==0: pc, stack, count and flags all hold regardless of op.
- pc_en==1, single-cycle update; the new pc is visible the cycle after the edge:
  - INC: pc <= pc+1.
  - BREL: cond ? pc <= pc+disp : pc <= pc+1.
  - JABS: cond ? pc <= target : pc <= pc+1.
  - CALL, stack not full: push pc+1, count+1, pc <= target.
  - CALL, stack full: pc holds, stack unchanged, stack_ovf <= 1.
  - RET, stack not empty: pc <= top entry, count-1.
  - RET, stack empty: pc holds, stack_unf <= 1.
  - HOLD (101-111): pc and stack hold, flags unchanged.
- Arithmetic:
  - All PC arithmetic is modulo 2^PC_WIDTH; disp is sign-extended, carries are discarded.
  - pc=all-ones with INC wraps to 0.
  - pc=0 with BREL disp=-1 wraps to all-ones.
- cond is ignored for INC, CALL and RET.
- Sticky flags clear only on reset.
- CALL immediately followed by RET on the next enabled cycle returns to the pushed address; no bypass hazard exists because the push commits at the edge.
- The stack is a true LIFO: no wrap-around, and count is saturated by the full/empty rules.

Decomposition:
- Shared package pc_pkg:
  - op encodings as localparams/enum: OP_INC, OP_BREL, OP_JABS, OP_CALL, OP_RET.
  - Default PC_WIDTH and STACK_DEPTH constants.
- Sub-module ret_stack (LIFO):
  - Parameters WIDTH, DEPTH.
  - Ports: clk, reset, push, pop, din, dout (top), empty, full.
  - ret_stack ignores push when full and pop when empty.
- pc_unit owns the next-PC mux and the sticky flags.

Test Plan:
- Reset held low 2 cycles with RESET_VECTOR=0x010 -> pc=0x010, stack_empty=1, stack_ovf=0, stack_unf=0; then INC ×3 -> pc=0x013; pc_en=0 for 2 cycles -> pc stays 0x013.
- pc=0x100, BREL disp=-4 (0x3FC), cond=1 -> pc=0x0FC; BREL disp=+8, cond=0 -> pc=0x0FD; JABS target=0x2AA, cond=1 -> pc=0x2AA.
- PC_WIDTH=10: pc=0x3FF, INC -> pc=0x000; pc=0x000, BREL disp=0x3FF, cond=1 -> pc=0x3FF.
- Nested CALLs from pc=0x020 to 0x100, 0x200, 0x300 -> stack holds 0x021, 0x101, 0x201; three RETs -> pc=0x201, 0x101, 0x021; stack_empty=1 after the third.
- STACK_DEPTH=4: 4 CALLs -> stack_full=1; 5th CALL target=0x3F0 -> pc unchanged, stack_ovf=1; after reset, RET on empty stack -> pc holds, stack_unf=1, stays 1 through subsequent INCs.
- Reset asserted during a CALL cycle (op=CALL, pc_en=1, reset=0) -> pc=RESET_VECTOR, stack_empty=1, no push recorded; op=101 with pc_en=1 -> no change.
